// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: debounced active-low matrix keypad scanner with single-key events, auto-repeat and multi-key lockout
module keypad_matrix_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DEBOUNCE     = 2,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4,
    parameter int CODE_W       = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              repeat_en,
    input  logic [ROWS-1:0]   keyboard_row,
    output logic [COLS-1:0]   keyboard_col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_press,
    output logic              key_repeat,
    output logic              key_release,
    output logic              multi_key
);
    localparam int N      = ROWS*COLS;
    localparam int CW     = $clog2(COLS);
    localparam int DW     = $clog2(DEBOUNCE+1);
    localparam int RW     = $clog2(REPEAT_DELAY+1);
    localparam int RELOAD = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY-REPEAT_RATE : 0;

    typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [N-1:0]      raw_q, raw_d, prev_q, prev_d, acc_q, acc_d, frame;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rpt_q, rpt_d, rpt_inc;
    logic [CODE_W-1:0] code_q, code_d, k;
    logic [ROWS-1:0]   sense;
    logic              tick_q, tick_d, press_q, press_d, repeat_q, repeat_d, release_q, release_d;
    logic              complete, one;

    // Frame bit c*ROWS+r is the key with code c*ROWS+r, so the frame doubles as a code-indexed key map.
    always_comb begin
        for (int r = 0; r < ROWS; r++) sense[r] = ~keyboard_row[ROWS-1-r];
        frame = raw_q;
        for (int c = 0; c < COLS; c++) if (col_q == CW'(c)) frame[c*ROWS +: ROWS] = sense;
        raw_d = scan_en ? frame : raw_q;
        complete = scan_en && col_q == CW'(COLS-1);
        col_d = scan_en ? (complete ? '0 : col_q + 1'b1) : col_q;
        cnt_d = cnt_q;
        prev_d = prev_q;
        acc_d = acc_q;
        tick_d = 1'b0;
        if (complete) begin
            cnt_d = frame != prev_q ? DW'(1) : (cnt_q == DW'(DEBOUNCE) ? cnt_q : cnt_q + 1'b1);
            prev_d = frame;
            tick_d = cnt_d == DW'(DEBOUNCE);
            acc_d = tick_d ? frame : acc_q;
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) keyboard_col[COLS-1-c] = col_q != CW'(c);
        one = acc_q != '0 && (acc_q & (acc_q - 1'b1)) == '0;
        k = '0;
        for (int i = 0; i < N; i++) if (acc_q[i]) k = CODE_W'(i);
    end

    // A held key only ever leaves through IDLE, so switching keys always passes through a release.
    always_comb begin
        state_d = state_q;
        code_d = code_q;
        rpt_d = rpt_q;
        press_d = 1'b0;
        repeat_d = 1'b0;
        release_d = 1'b0;
        rpt_inc = rpt_q + 1'b1;
        if (tick_q) begin
            case (state_q)
                IDLE: begin
                    if (one) begin
                        state_d = HELD;
                        code_d = k;
                        press_d = 1'b1;
                        rpt_d = '0;
                    end else if (acc_q != '0) state_d = LOCK;
                end
                HELD: begin
                    if (acc_q == '0) begin
                        state_d = IDLE;
                        release_d = 1'b1;
                    end else if (!one || k != code_q) begin
                        state_d = LOCK;
                        release_d = 1'b1;
                    end else if (rpt_inc == RW'(REPEAT_DELAY)) begin
                        press_d = repeat_en;
                        repeat_d = repeat_en;
                        rpt_d = RW'(RELOAD);
                    end else rpt_d = rpt_inc;
                end
                default: state_d = acc_q == '0 ? IDLE : state_q;
            endcase
        end
        if (!repeat_en) rpt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q <= '0;
            raw_q <= '0;
            prev_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            rpt_q <= '0;
            code_q <= '0;
            tick_q <= 1'b0;
            press_q <= 1'b0;
            repeat_q <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            raw_q <= raw_d;
            prev_q <= prev_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            rpt_q <= rpt_d;
            code_q <= code_d;
            tick_q <= tick_d;
            press_q <= press_d;
            repeat_q <= repeat_d;
            release_q <= release_d;
        end
    end

    assign key_valid = state_q == HELD;
    assign multi_key = state_q == LOCK;
    assign key_code = code_q;
    assign key_press = press_q;
    assign key_repeat = repeat_q;
    assign key_release = release_q;
endmodule
